// File: rtl/commit_sequencer_pkg.sv
// Shared constants for the commit sequencer: commit type codes, widths, zero constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package commit_sequencer_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int ROB_W  = 4;
  localparam int CNT_W  = 32;

  localparam logic [1:0] COMMIT_REG    = 2'b00;
  localparam logic [1:0] COMMIT_STORE  = 2'b01;
  localparam logic [1:0] COMMIT_BRANCH = 2'b10;
  localparam logic [1:0] COMMIT_HALT   = 2'b11;

  localparam logic [ROB_W-1:0] ROB_ZERO = '0;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/commit_sequencer.sv
// Retires the ROB head in program order: reg writes, store handshake, misbranch flush, halt.
// Latency: zero added; commit/pop/store-go/misbranch are combinational from state and head.
// Backpressure: rdy low freezes everything; a store holds retirement until in_lsb_store_done.
module commit_sequencer
  import commit_sequencer_pkg::*;
#(
  parameter int DATA_W = commit_sequencer_pkg::DATA_W,
  parameter int REG_W  = commit_sequencer_pkg::REG_W,
  parameter int ROB_W  = commit_sequencer_pkg::ROB_W,
  parameter int CNT_W  = commit_sequencer_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_head_valid,
  input  logic              in_head_ready,
  input  logic [1:0]        in_head_type,
  input  logic [ROB_W-1:0]  in_head_tag,
  input  logic [REG_W-1:0]  in_head_dest,
  input  logic [DATA_W-1:0] in_head_value,
  input  logic              in_head_mispredict,
  input  logic [DATA_W-1:0] in_head_target,
  output logic              out_rob_pop,
  output logic [REG_W-1:0]  out_reg_commit_reg,
  output logic [ROB_W-1:0]  out_reg_commit_rob,
  output logic [DATA_W-1:0] out_reg_commit_value,
  output logic              out_misbranch,
  output logic [DATA_W-1:0] out_redirect_pc,
  output logic              out_lsb_store_go,
  output logic [ROB_W-1:0]  out_lsb_store_rob,
  input  logic              in_lsb_store_done,
  output logic              out_halt,
  output logic [CNT_W-1:0]  out_commit_count
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_STORE_WAIT = 2'd1,
    S_FLUSH      = 2'd2,
    S_HALTED     = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ROB_W-1:0]  store_tag, store_tag_nxt;
  logic [CNT_W-1:0]  count;
  logic              head_ok;

  assign head_ok = in_head_valid & in_head_ready;

  // Next state and all combinational outputs; reset and rdy low both idle every pulse.
  always_comb begin
    state_nxt            = state;
    store_tag_nxt        = store_tag;
    out_rob_pop          = 1'b0;
    out_reg_commit_reg   = '0;
    out_reg_commit_rob   = '0;
    out_reg_commit_value = '0;
    out_misbranch        = 1'b0;
    out_redirect_pc      = '0;
    out_lsb_store_go     = 1'b0;
    // The outstanding store tag stays visible for the whole wait, even while frozen.
    out_lsb_store_rob    = (!rst && state == S_STORE_WAIT) ? store_tag : '0;

    if (rdy && !rst) begin
      unique case (state)
        S_IDLE: begin
          if (head_ok) begin
            unique case (in_head_type)
              COMMIT_REG: begin
                out_reg_commit_reg   = in_head_dest;
                out_reg_commit_rob   = in_head_tag;
                out_reg_commit_value = in_head_value;
                out_rob_pop          = 1'b1;
              end
              COMMIT_STORE: begin
                out_lsb_store_go  = 1'b1;
                out_lsb_store_rob = in_head_tag;
                store_tag_nxt     = in_head_tag;
                state_nxt         = S_STORE_WAIT;
              end
              COMMIT_BRANCH: begin
                // Link register write for jal/jalr; dest 0 for plain branches.
                out_reg_commit_reg   = in_head_dest;
                out_reg_commit_rob   = in_head_tag;
                out_reg_commit_value = in_head_value;
                out_rob_pop          = 1'b1;
                if (in_head_mispredict) begin
                  out_misbranch   = 1'b1;
                  out_redirect_pc = in_head_target;
                  state_nxt       = S_FLUSH;
                end
              end
              default: begin
                out_rob_pop = 1'b1;
                state_nxt   = S_HALTED;
              end
            endcase
          end
        end
        S_STORE_WAIT: begin
          if (in_lsb_store_done) begin
            out_rob_pop = 1'b1;
            state_nxt   = S_IDLE;
          end
        end
        S_FLUSH: begin
          // The ROB is clearing this cycle; whatever sits at the head is stale.
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_HALTED;
        end
      endcase
    end
  end

  // State, pending store tag and retirement counter; all hold while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      store_tag <= '0;
      count     <= '0;
    end else if (rdy) begin
      state     <= state_nxt;
      store_tag <= store_tag_nxt;
      if (out_rob_pop) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  assign out_halt         = (state == S_HALTED);
  assign out_commit_count = count;

endmodule
